reg_writeback_arbiter: RTL and testbench

- Producer side of the register file's single write port (write_enable / write_index3 / write_data3); owns all traffic into that port.
- Merges single-cycle ALU results with variable-latency load results, buffering loads in a small FIFO.
- Keeps a 32-entry pending-destination scoreboard that the hazard logic queries before issuing.
- Sits between the execute/memory stages and register_file.

---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_fifo.sv | 38 +++
 rtl/reg_writeback_arbiter.sv | 71 +++++++
 tb/tb_reg_writeback_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the writeback entry type for the register write port
package wb_pkg;
  localparam int IDX_W = 5;
  localparam int DATA_W = 32;
  localparam logic [IDX_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of load results awaiting the register write port
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  wb_entry_t                  din,
  output wb_entry_t                  dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wp, rp;
  wb_entry_t mem [DEPTH];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  // storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter: merges ALU and load results onto the register write port and tracks pending writes
module reg_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [IDX_W-1:0]       alu_index,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [IDX_W-1:0]       mem_index,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic                   reserve_valid,
  input  logic [IDX_W-1:0]       reserve_index,
  input  logic [IDX_W-1:0]       qa1,
  input  logic [IDX_W-1:0]       qa2,
  output logic                   busy1,
  output logic                   busy2,
  output logic                   write_enable,
  output logic [IDX_W-1:0]       write_index3,
  output logic [DATA_W-1:0]      write_data3,
  output logic [$clog2(DEPTH):0] fifo_count
);
  import wb_pkg::*;
  localparam int NREG = 2 ** IDX_W;
  wb_entry_t head, sel;
  logic full, empty, push, pop, sel_valid, we_next;
  logic [NREG-1:0] pending, clr, set;
  assign mem_ready = !full;
  assign push = mem_valid && mem_ready;
  assign pop = !alu_valid && !empty;
  assign sel_valid = alu_valid || !empty;
  assign we_next = sel_valid && sel.index != REG_ZERO;
  assign busy1 = pending[qa1] && qa1 != REG_ZERO;
  assign busy2 = pending[qa2] && qa2 != REG_ZERO;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ('{index: mem_index, data: mem_data}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
  // ALU results always win the port; loads drain only in ALU-free cycles
  always_comb begin
    sel = alu_valid ? '{index: alu_index, data: alu_data} : head;
    clr = we_next ? NREG'(1) << sel.index : '0;
    set = (reserve_valid && reserve_index != REG_ZERO) ? NREG'(1) << reserve_index : '0;
  end
  // output stage: index 0 still shows on the port but never enables the write
  always_ff @(posedge clk)
    if (reset) begin
      write_enable <= 1'b0;
      write_index3 <= '0;
      write_data3 <= '0;
    end else begin
      write_enable <= we_next;
      write_index3 <= sel_valid ? sel.index : write_index3;
      write_data3 <= sel_valid ? sel.data : write_data3;
    end
  // pending scoreboard: a same-cycle reserve outranks the clear of a retiring producer
  always_ff @(posedge clk)
    if (reset) pending <= '0;
    else pending <= (pending & ~clr) | set;
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// tb_reg_writeback_arbiter: directed checks of writeback arbitration, FIFO and scoreboard
module tb_reg_writeback_arbiter;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1;
  logic alu_valid = 0, mem_valid = 0, reserve_valid = 0;
  logic [4:0] alu_index = 0, mem_index = 0, reserve_index = 0, qa1 = 0, qa2 = 0;
  logic [31:0] alu_data = 0, mem_data = 0;
  logic mem_ready, busy1, busy2, write_enable;
  logic [4:0] write_index3;
  logic [31:0] write_data3;
  logic [2:0] fifo_count;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  reg_writeback_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .IDX_W(5)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_index(alu_index), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_index(mem_index), .mem_data(mem_data),
    .reserve_valid(reserve_valid), .reserve_index(reserve_index),
    .qa1(qa1), .qa2(qa2), .busy1(busy1), .busy2(busy2),
    .write_enable(write_enable), .write_index3(write_index3), .write_data3(write_data3),
    .fifo_count(fifo_count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input string tag, input logic we, input logic [4:0] idx, input logic [31:0] d);
    chk({tag, "_we"}, write_enable, we);
    chk({tag, "_idx"}, write_index3, idx);
    chk({tag, "_data"}, write_data3, d);
  endtask
  initial begin
    step();
    step();
    wr("reset", 0, 0, 0);
    chk("reset_count", fifo_count, 0);
    chk("reset_ready", mem_ready, 1);
    chk("reset_busy1", busy1, 0);
    reset = 0;
    alu_valid = 1; alu_index = 3; alu_data = 32'h1234;
    step();
    wr("alu", 1, 3, 32'h1234);
    alu_valid = 0;
    step();
    chk("alu_done_we", write_enable, 0);
    mem_valid = 1; mem_index = 5; mem_data = 32'hDEAD;
    chk("ld_ready", mem_ready, 1);
    step();
    mem_valid = 0;
    chk("ld_lat1_we", write_enable, 0);
    chk("ld_count1", fifo_count, 1);
    step();
    wr("ld", 1, 5, 32'hDEAD);
    chk("ld_count0", fifo_count, 0);
    mem_valid = 1; mem_index = 7; mem_data = 32'h77;
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1; alu_index = 8; alu_data = 32'h80 + k;
      step();
      mem_valid = 0;
      wr("stall_alu", 1, 8, 32'h80 + k);
    end
    chk("stall_count", fifo_count, 1);
    alu_valid = 0;
    step();
    wr("stall_ld", 1, 7, 32'h77);
    alu_valid = 1; alu_index = 1; alu_data = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_valid = 1; mem_index = 5'(10 + i); mem_data = 32'hA0 + i;
      step();
    end
    chk("full_count", fifo_count, DEPTH);
    chk("full_ready", mem_ready, 0);
    mem_index = 14; mem_data = 32'hA4;
    step();
    chk("full_hold", fifo_count, DEPTH);
    alu_valid = 0;
    step();
    chk("full_poprefuse", fifo_count, 3);
    wr("drain0", 1, 10, 32'hA0);
    step();
    mem_valid = 0;
    chk("pushpop_count", fifo_count, 3);
    wr("drain1", 1, 11, 32'hA1);
    for (int i = 2; i < 5; i++) begin
      step();
      wr("drain", 1, 5'(10 + i), 32'hA0 + i);
      chk("drain_count", fifo_count, 3'(4 - i));
    end
    step();
    reserve_valid = 1; reserve_index = 9; qa1 = 9; qa2 = 4;
    step();
    reserve_valid = 0;
    chk("rsv_busy1", busy1, 1);
    chk("rsv_busy2", busy2, 0);
    alu_valid = 1; alu_index = 9; alu_data = 32'h99;
    chk("rsv_before_clr", busy1, 1);
    step();
    chk("clr_busy1", busy1, 0);
    reserve_valid = 1; reserve_index = 9;
    step();
    reserve_valid = 0;
    chk("setwins_busy1", busy1, 1);
    step();
    chk("reclr_busy1", busy1, 0);
    alu_valid = 0;
    reserve_valid = 1; reserve_index = 0; qa2 = 0;
    step();
    chk("rsv0_busy2", busy2, 0);
    reserve_index = 6; qa2 = 6;
    step();
    reserve_valid = 0;
    chk("rsv6_busy2", busy2, 1);
    alu_valid = 1; alu_index = 0; alu_data = 32'h55;
    step();
    wr("r0", 0, 0, 32'h55);
    chk("r0_busy2", busy2, 1);
    alu_index = 1;
    reserve_valid = 1; reserve_index = 12; qa1 = 12;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1; mem_index = 5'(20 + i); mem_data = 32'hB0 + i;
      step();
      reserve_valid = 0;
    end
    mem_valid = 0;
    chk("pre_rst_count", fifo_count, 3);
    chk("pre_rst_busy1", busy1, 1);
    reset = 1;
    mem_valid = 1; reserve_valid = 1; reserve_index = 12;
    step();
    chk("rst_count", fifo_count, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_ready", mem_ready, 1);
    reset = 0; alu_valid = 0; mem_valid = 0; reserve_valid = 0;
    step();
    chk("post_rst_we", write_enable, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
